// File: rtl/vu_frame_ctrl.sv
// VU-meter pixel scheduler: raster counters in lockstep with vga, frame-latched
// left/right levels, green/yellow/red bars and a decaying peak-hold marker.
module vu_frame_ctrl #(
  parameter int THADDR      = 640,
  parameter int THFP        = 16,
  parameter int THS         = 96,
  parameter int THBP        = 48,
  parameter int THBD        = 0,
  parameter int TVADDR      = 480,
  parameter int TVFP        = 10,
  parameter int TVS         = 2,
  parameter int TVBP        = 33,
  parameter int TVBD        = 0,
  parameter int C_SIZE      = 10,
  parameter int LEAD        = 1,
  parameter int BAR_L_X     = 100,
  parameter int BAR_R_X     = 400,
  parameter int BAR_W       = 64,
  parameter int YEL_TH      = 320,
  parameter int RED_TH      = 420,
  parameter int HOLD_FRAMES = 30
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              level_valid,
  output logic              level_ready,
  input  logic [C_SIZE-1:0] level_l,
  input  logic [C_SIZE-1:0] level_r,
  output logic [7:0]        data,
  output logic              frame_start
);

  localparam int H_TOTAL = THADDR + 2*THBD + THFP + THS + THBP;
  localparam int V_TOTAL = TVADDR + 2*TVBD + TVFP + TVS + TVBP;

  localparam logic [C_SIZE-1:0] H_LAST = C_SIZE'(H_TOTAL - 1);
  localparam logic [C_SIZE-1:0] V_LAST = C_SIZE'(V_TOTAL - 1);
  localparam logic [C_SIZE-1:0] H_INIT = C_SIZE'(LEAD % H_TOTAL);
  localparam logic [C_SIZE-1:0] V_INIT = C_SIZE'((LEAD / H_TOTAL) % V_TOTAL);
  localparam logic [C_SIZE-1:0] H_ACT  = C_SIZE'(THADDR);
  localparam logic [C_SIZE-1:0] V_ACT  = C_SIZE'(TVADDR);
  localparam logic [C_SIZE-1:0] V_TOP  = C_SIZE'(TVADDR - 1);
  localparam logic [C_SIZE-1:0] LX0    = C_SIZE'(BAR_L_X);
  localparam logic [C_SIZE-1:0] RX0    = C_SIZE'(BAR_R_X);
  localparam logic [C_SIZE-1:0] BW     = C_SIZE'(BAR_W);
  localparam logic [C_SIZE-1:0] YEL    = C_SIZE'(YEL_TH);
  localparam logic [C_SIZE-1:0] RED    = C_SIZE'(RED_TH);
  localparam logic [C_SIZE-1:0] HOLD   = C_SIZE'(HOLD_FRAMES);
  localparam logic [C_SIZE-1:0] ONE    = C_SIZE'(1);

  // Handshake: a level pair transfers in any cycle where level_valid and
  // level_ready are both high at the rising edge; both channels load together.

  logic [C_SIZE-1:0] h_q, h_d, v_q, v_d;
  logic [C_SIZE-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [C_SIZE-1:0] disp_l_q, disp_l_d, disp_r_q, disp_r_d;
  logic [C_SIZE-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [C_SIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [7:0]        data_q, data_d;
  logic              frame_start_q, frame_start_d;
  logic              ready_q, ready_d;

  logic              update;
  logic              accept;
  logic              active;
  logic [C_SIZE-1:0] y;

  function automatic logic [2*C_SIZE-1:0] peak_next(
    input logic [C_SIZE-1:0] lvl,
    input logic [C_SIZE-1:0] pk,
    input logic [C_SIZE-1:0] hd
  );
    logic [C_SIZE-1:0] pk_n;
    logic [C_SIZE-1:0] hd_n;
    pk_n = pk;
    hd_n = hd;
    if (lvl > pk) begin
      pk_n = lvl;
      hd_n = HOLD;
    end else if (hd != '0) begin
      hd_n = hd - ONE;
    end else if (pk > lvl) begin
      pk_n = pk - ONE;
    end
    return {pk_n, hd_n};
  endfunction

  function automatic logic [7:0] bar_pix(
    input logic [C_SIZE-1:0] yy,
    input logic [C_SIZE-1:0] lvl,
    input logic [C_SIZE-1:0] pk
  );
    logic [7:0] c;
    c = 8'h00;
    if (yy < lvl) begin
      if (yy < YEL)      c = 8'h1C;
      else if (yy < RED) c = 8'hFC;
      else               c = 8'hE0;
    end else if ((pk > lvl) && (yy == pk - ONE)) begin
      c = 8'hFF;
    end
    return c;
  endfunction

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    pend_l_d      = pend_l_q;
    pend_r_d      = pend_r_q;
    disp_l_d      = disp_l_q;
    disp_r_d      = disp_r_q;
    peak_l_d      = peak_l_q;
    peak_r_d      = peak_r_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    data_d        = 8'h00;
    ready_d       = 1'b1;
    update        = (h_q == '0) && (v_q == '0);
    accept        = level_valid && ready_q;
    frame_start_d = update && ready_q;
    active        = (h_q < H_ACT) && (v_q < V_ACT);
    y             = V_TOP - v_q;

    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
    end else begin
      h_d = h_q + ONE;
    end

    // The pixel at index 0 already belongs to the new frame, so colour uses the _d values.
    if (update) begin
      disp_l_d             = pend_l_q;
      disp_r_d             = pend_r_q;
      {peak_l_d, hold_l_d} = peak_next(pend_l_q, peak_l_q, hold_l_q);
      {peak_r_d, hold_r_d} = peak_next(pend_r_q, peak_r_q, hold_r_q);
    end

    if (accept) begin
      pend_l_d = (level_l > V_ACT) ? V_ACT : level_l;
      pend_r_d = (level_r > V_ACT) ? V_ACT : level_r;
    end

    // Column tests use wrapping subtraction so a bar at column 0 needs no special case.
    if (active) begin
      if ((h_q - LX0) < BW)      data_d = bar_pix(y, disp_l_d, peak_l_d);
      else if ((h_q - RX0) < BW) data_d = bar_pix(y, disp_r_d, peak_r_d);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      h_q           <= H_INIT;
      v_q           <= V_INIT;
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      disp_l_q      <= '0;
      disp_r_q      <= '0;
      peak_l_q      <= '0;
      peak_r_q      <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      data_q        <= 8'h00;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      disp_l_q      <= disp_l_d;
      disp_r_q      <= disp_r_d;
      peak_l_q      <= peak_l_d;
      peak_r_q      <= peak_r_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
    end
  end

  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign level_ready = ready_q;

endmodule

// File: doc/vu_frame_ctrl.md
Name: vu_frame_ctrl

Overview:
- Pixel-data scheduler that drives the `data` input of the vga timing block for the VU-meter display.
- Keeps raster counters that run in lockstep with vga and accepts left/right level samples through a valid/ready handshake.
- Latches the levels only at frame boundaries, so bars never tear mid-frame.
- Renders two vertical bar meters with green/yellow/red zones and a peak-hold marker that decays over time.

Parameters:
THADDR, 640, horizontal active pixels (same value as the vga instance)
THFP, 16, horizontal front porch
THS, 96, horizontal sync width
THBP, 48, horizontal back porch
THBD, 0, horizontal border (each side)
TVADDR, 480, vertical active lines
TVFP, 10, vertical front porch
TVS, 2, vertical sync width
TVBP, 33, vertical back porch
TVBD, 0, vertical border (each side)
C_SIZE, 10, counter and level width
LEAD, 1, raster-index lead of data relative to output cycle (see Behaviour)
BAR_L_X, 100, first column of the left bar
BAR_R_X, 400, first column of the right bar
BAR_W, 64, bar width in pixels
YEL_TH, 320, bar height at which yellow starts
RED_TH, 420, bar height at which red starts
HOLD_FRAMES, 30, frames the peak is held before it decays

Ports:
pixel_clock  in  1  pixel clock
reset  in  1  synchronous, active-high reset
level_valid  in  1  level sample offered
level_ready  out  1  level sample can be accepted
level_l  in  C_SIZE  left level, in pixels of bar height
level_r  in  C_SIZE  right level, in pixels of bar height
data  out  8  pixel colour {R[2:0],G[2:0],B[1:0]} to vga
frame_start  out  1  one-cycle pulse at the start of a new displayed frame

Behaviour:
- One clock domain: pixel_clock. Reset is synchronous and active-high.
- Reset values: data=8'h00, level_ready=0, frame_start=0. Pending levels, display levels, peaks and hold counters all clear to 0.
- Raster geometry:
  - H_TOTAL = THADDR+2*THBD+THFP+THS+THBP
  - V_TOTAL = TVADDR+2*TVBD+TVFP+TVS+TVBP
  - raster index = v*H_TOTAL + h; active pixels are h<THADDR and v<TVADDR, starting at index 0.
  - All counter arithmetic is in C_SIZE bits; wrap from FRAME-1 to 0.
- Output timing:
  - data is registered.
  - In cycle n (n=0 is the first cycle after reset deasserts), data carries the colour of raster index (n+LEAD-1) mod FRAME, where FRAME = H_TOTAL*V_TOTAL.
  - The vga instance is reset in the same cycle as this block.
- Handshake:
  - level_ready=1 from the first cycle after reset onward.
  - A sample is accepted when level_valid && level_ready; both channels load the pending registers together.
  - Values above TVADDR are clipped to TVADDR on acceptance.
- Frame update (the cycle that computes raster index 0):
  - display ← pending; the peak logic runs for each channel.
  - A sample accepted in this same cycle goes to pending only, so it is displayed from the following frame.
  - frame_start=1 in the cycle data carries index 0. It is not asserted for the first frame after reset.
- Peak logic (per channel, at each frame update, using the new display level L):
  - L>peak: peak=L, hold=HOLD_FRAMES.
  - Else if hold>0: hold−1.
  - Else if peak>L: peak−1.
  - Else: no change.
- Pixel colour for an active pixel, with bar height position y = TVADDR−1−v:
  - Inside bar columns [X, X+BAR_W) of a channel with display level L:
    - y < L: lit. Colour is green 8'h1C if y<YEL_TH, yellow 8'hFC if y<RED_TH, otherwise red 8'hE0.
    - y == peak−1 and peak>L: white 8'hFF.
    - Otherwise 8'h00.
  - Outside the bars, and all blanking, border, porch and sync positions: 8'h00.
  - If the two bars overlap, the left bar has priority.
- Reset mid-operation: in the next cycle data=0 and all state is cleared. Counters restart as after the initial reset. Any pending sample is lost.

Test Plan (THADDR=4, THFP=1, THS=3, THBP=2, THBD=0, TVADDR=4, TVFP=1, TVS=3, TVBP=2, TVBD=0, C_SIZE=8, LEAD=1, BAR_L_X=0, BAR_R_X=2, BAR_W=1, YEL_TH=2, RED_TH=3, HOLD_FRAMES=1, giving FRAME=100):
1. Reset held 5 cycles, then released with no samples → data=00, level_ready=1 from cycle 1, frame_start pulses at cycles 100, 200…, and data stays 00 throughout.
2. Sample L=3, R=4 accepted in cycle 40 → frame 0 unchanged. Frame 1:
   - h=0 column: v=3 1C, v=2 1C, v=1 FC, v=0 00.
   - h=2 column: v=3 1C, v=2 1C, v=1 FC, v=0 E0.
   - All other pixels 00.
3. Sample L=200 → clipped to 4; the left column shows the full 1C,1C,FC,E0 next frame.
4. L=4 for one frame, then L=1:
   - Next frame: peak 4, hold 1→0, white FF at v=0.
   - Following frames: marker moves to v=1 (peak 3), then v=2 (peak 2), then disappears once peak=1.
5. Sample accepted exactly in the frame-update cycle → not shown in the frame beginning then; shown in the frame after.
6. Reset pulsed for 1 cycle at cycle 150 with bars lit → data=00 from cycle 151, no frame_start at 200, bars empty until a new sample is accepted.
